// File: rtl/complete_rr_arbiter.sv
// Complete stage: round-robin CDB arbiter with one held slot per FU.
// All outputs registered; squash drops held and in-flight results.
module complete_rr_arbiter #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int XLEN   = 32,
  parameter int PR_W   = 6,
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int LW = (CDB_W > 1) ? $clog2(CDB_W) : 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_finish,
  input  logic [NUM_FU-1:0][PR_W-1:0]      fu_dest_pr,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_dest_value,
  input  logic [NUM_FU-1:0]                fu_take_branch,
  output logic [NUM_FU-1:0]                fu_stall,
  output logic [CDB_W-1:0]                 cdb_valid,
  output logic [CDB_W-1:0][PR_W-1:0]       cdb_tag,
  output logic [CDB_W-1:0][XLEN-1:0]       wb_value,
  output logic [CDB_W-1:0]                 cdb_take_branch,
  output logic [CDB_W-1:0][IW-1:0]         cdb_fu_idx
);

  logic [NUM_FU-1:0]           held_v_q, held_v_d;
  logic [NUM_FU-1:0][PR_W-1:0] held_tag_q, held_tag_d;
  logic [NUM_FU-1:0][XLEN-1:0] held_val_q, held_val_d;
  logic [NUM_FU-1:0]           held_br_q, held_br_d;
  logic [IW-1:0]               rr_ptr_q, rr_ptr_d;

  logic [CDB_W-1:0]            valid_q, valid_d;
  logic [CDB_W-1:0][PR_W-1:0]  tag_q, tag_d;
  logic [CDB_W-1:0][XLEN-1:0]  val_q, val_d;
  logic [CDB_W-1:0]            br_q, br_d;
  logic [CDB_W-1:0][IW-1:0]    idx_q, idx_d;

  logic [NUM_FU-1:0]           cand, grant;
  logic [NUM_FU-1:0][PR_W-1:0] src_tag;
  logic [NUM_FU-1:0][XLEN-1:0] src_val;
  logic [NUM_FU-1:0]           src_br;
  logic [IW-1:0]               last;
  int                          cnt;
  int                          idx;

  // A held slot masks the FU inputs, so a finish while stalled is ignored.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      cand[i]    = held_v_q[i] | fu_finish[i];
      src_tag[i] = held_v_q[i] ? held_tag_q[i] : fu_dest_pr[i];
      src_val[i] = held_v_q[i] ? held_val_q[i] : fu_dest_value[i];
      src_br[i]  = held_v_q[i] ? held_br_q[i]  : fu_take_branch[i];
    end
  end

  always_comb begin
    grant   = '0;
    valid_d = '0;
    tag_d   = '0;
    val_d   = '0;
    br_d    = '0;
    idx_d   = '0;
    cnt     = 0;
    idx     = 0;
    last    = rr_ptr_q;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (cand[IW'(idx)] && cnt < CDB_W) begin
        grant[IW'(idx)]  = 1'b1;
        valid_d[LW'(cnt)] = 1'b1;
        tag_d[LW'(cnt)]  = src_tag[IW'(idx)];
        val_d[LW'(cnt)]  = src_val[IW'(idx)];
        br_d[LW'(cnt)]   = src_br[IW'(idx)];
        idx_d[LW'(cnt)]  = IW'(idx);
        last             = IW'(idx);
        cnt              = cnt + 1;
      end
    end
    if (squash) valid_d = '0;
  end

  always_comb begin
    held_v_d   = squash ? '0 : (cand & ~grant);
    held_tag_d = held_tag_q;
    held_val_d = held_val_q;
    held_br_d  = held_br_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (!held_v_q[i] && fu_finish[i]) begin
        held_tag_d[i] = fu_dest_pr[i];
        held_val_d[i] = fu_dest_value[i];
        held_br_d[i]  = fu_take_branch[i];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (!squash && cnt != 0)
      rr_ptr_d = (int'(last) == NUM_FU - 1) ? '0 : last + IW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_v_q   <= '0;
      held_tag_q <= '0;
      held_val_q <= '0;
      held_br_q  <= '0;
      rr_ptr_q   <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      val_q      <= '0;
      br_q       <= '0;
      idx_q      <= '0;
    end else begin
      held_v_q   <= held_v_d;
      held_tag_q <= held_tag_d;
      held_val_q <= held_val_d;
      held_br_q  <= held_br_d;
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      val_q      <= val_d;
      br_q       <= br_d;
      idx_q      <= idx_d;
    end
  end

  assign fu_stall        = held_v_q;
  assign cdb_valid       = valid_q;
  assign cdb_tag         = tag_q;
  assign wb_value        = val_q;
  assign cdb_take_branch = br_q;
  assign cdb_fu_idx      = idx_q;

endmodule

// File: tb/tb_complete_rr_arbiter.sv
// Bench for complete_rr_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_complete_rr_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic squash = 1'b0;
  logic [N-1:0] fin = '0;
  logic [N-1:0][5:0] pr = '0;
  logic [N-1:0][31:0] val = '0;
  logic [N-1:0] br = '0;
  logic [N-1:0] fu_stall;
  logic [W-1:0] cdb_valid;
  logic [W-1:0][5:0] cdb_tag;
  logic [W-1:0][31:0] wb_value;
  logic [W-1:0] cdb_take_branch;
  logic [W-1:0][2:0] cdb_fu_idx;

  int total = 0;
  int bad = 0;

  bit m_held[N];
  logic [5:0] m_tag[N];
  logic [31:0] m_val[N];
  bit m_br[N];
  int m_ptr;
  logic [W-1:0] e_valid;
  logic [5:0] e_tag[W];
  logic [31:0] e_val[W];
  bit e_br[W];
  int e_idx[W];

  always #5 clock = ~clock;

  complete_rr_arbiter dut (
    .clock(clock),
    .reset_n(reset_n),
    .squash(squash),
    .fu_finish(fin),
    .fu_dest_pr(pr),
    .fu_dest_value(val),
    .fu_take_branch(br),
    .fu_stall(fu_stall),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .wb_value(wb_value),
    .cdb_take_branch(cdb_take_branch),
    .cdb_fu_idx(cdb_fu_idx)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_held[i] = 0;
    m_ptr = 0;
    e_valid = '0;
  endtask

  // Collect candidates in scan order; first W broadcast, rest wait.
  task automatic model_step();
    int q[$];
    int i, n;
    e_valid = '0;
    if (squash) begin
      for (int j = 0; j < N; j++) m_held[j] = 0;
      return;
    end
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (m_held[i] || fin[i]) q.push_back(i);
    end
    for (int p = 0; p < q.size(); p++) begin
      i = q[p];
      if (p < W) begin
        e_valid[p] = 1'b1;
        e_tag[p] = m_held[i] ? m_tag[i] : pr[i];
        e_val[p] = m_held[i] ? m_val[i] : val[i];
        e_br[p] = m_held[i] ? m_br[i] : br[i];
        e_idx[p] = i;
        m_held[i] = 0;
      end else if (!m_held[i]) begin
        m_tag[i] = pr[i];
        m_val[i] = val[i];
        m_br[i] = br[i];
        m_held[i] = 1;
      end
    end
    if (q.size() > 0) begin
      n = (q.size() < W) ? q.size() : W;
      m_ptr = (q[n-1] + 1) % N;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] f);
    fin = f;
    squash = 1'b0;
    for (int i = 0; i < N; i++) begin
      pr[i] = 6'(i + 8);
      val[i] = 32'h1000_0000 + i;
      br[i] = (i % 2 == 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    set_in('0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    set_in(8'hFF);
    tick();
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (fu_stall !== 8'h00 || cdb_valid !== 3'b000) begin
      bad++;
      $display("FAIL reset_async stall=%b valid=%b exp 0/0", fu_stall, cdb_valid);
    end
    total++;
    if (cdb_tag !== '0 || wb_value !== '0 || cdb_take_branch !== '0 || cdb_fu_idx !== '0) begin
      bad++;
      $display("FAIL reset_lanes tag=%h val=%h br=%b idx=%h exp 0", cdb_tag, wb_value, cdb_take_branch, cdb_fu_idx);
    end
    @(negedge clock);
    set_in('0);
    reset_n = 1'b1;
    tick();
    total++;
    if (fu_stall !== 8'h00 || dut.rr_ptr_q !== 3'd0 || cdb_valid !== 3'b000) begin
      bad++;
      $display("FAIL reset_release stall=%b ptr=%0d valid=%b exp 0", fu_stall, dut.rr_ptr_q, cdb_valid);
    end
  endtask

  task automatic test_light_load();
    int ex[W] = '{0, 2, 4};
    do_reset();
    @(negedge clock);
    set_in(8'b00010101);
    pr[0] = 6'b001001;
    val[0] = 32'h71a230f1;
    tick();
    total++;
    if (cdb_valid !== 3'b111 || fu_stall !== 8'h00 || dut.rr_ptr_q !== 3'd5) begin
      bad++;
      $display("FAIL light_ctl valid=%b stall=%b ptr=%0d exp 111/0/5", cdb_valid, fu_stall, dut.rr_ptr_q);
    end
    for (int l = 0; l < W; l++) begin
      total++;
      if (cdb_fu_idx[l] !== 3'(ex[l]) || cdb_tag[l] !== (l == 0 ? 6'b001001 : 6'(ex[l] + 8))
          || wb_value[l] !== (l == 0 ? 32'h71a230f1 : 32'h1000_0000 + ex[l])) begin
        bad++;
        $display("FAIL light_lane%0d idx=%0d tag=%h val=%h exp fu%0d", l, cdb_fu_idx[l], cdb_tag[l], wb_value[l], ex[l]);
      end
    end
    @(negedge clock);
    set_in('0);
  endtask

  task automatic test_overload();
    logic [N-1:0] exs[3] = '{8'b11111000, 8'b11000000, 8'b00000000};
    logic [W-1:0] exv[3] = '{3'b111, 3'b111, 3'b011};
    do_reset();
    @(negedge clock);
    set_in(8'hFF);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (cdb_valid !== exv[c] || fu_stall !== exs[c]) begin
        bad++;
        $display("FAIL overload_c%0d valid=%b stall=%b exp %b/%b", c + 1, cdb_valid, fu_stall, exv[c], exs[c]);
      end
      for (int l = 0; l < W; l++) begin
        if (exv[c][l]) begin
          total++;
          if (cdb_fu_idx[l] !== 3'(3 * c + l) || wb_value[l] !== 32'h1000_0000 + 3 * c + l
              || cdb_take_branch[l] !== ((3 * c + l) % 2 == 1)) begin
            bad++;
            $display("FAIL overload_c%0d_lane%0d idx=%0d val=%h br=%b exp fu%0d", c + 1, l, cdb_fu_idx[l], wb_value[l], cdb_take_branch[l], 3 * c + l);
          end
        end
      end
      @(negedge clock);
      set_in('0);
    end
    total++;
    if (dut.rr_ptr_q !== 3'd0) begin
      bad++;
      $display("FAIL overload_ptr got=%0d exp=0", dut.rr_ptr_q);
    end
  endtask

  task automatic test_wrap();
    int ex[W] = '{6, 7, 0};
    do_reset();
    @(negedge clock);
    set_in(8'b00111000);
    tick();
    @(negedge clock);
    set_in(8'b11000011);
    tick();
    total++;
    if (cdb_valid !== 3'b111 || fu_stall !== 8'b00000010) begin
      bad++;
      $display("FAIL wrap_c1 valid=%b stall=%b exp 111/00000010", cdb_valid, fu_stall);
    end
    for (int l = 0; l < W; l++) begin
      total++;
      if (cdb_fu_idx[l] !== 3'(ex[l])) begin
        bad++;
        $display("FAIL wrap_lane%0d got=%0d exp=%0d", l, cdb_fu_idx[l], ex[l]);
      end
    end
    @(negedge clock);
    set_in('0);
    tick();
    total++;
    if (cdb_valid !== 3'b001 || cdb_fu_idx[0] !== 3'd1 || dut.rr_ptr_q !== 3'd2) begin
      bad++;
      $display("FAIL wrap_c2 valid=%b idx0=%0d ptr=%0d exp 001/1/2", cdb_valid, cdb_fu_idx[0], dut.rr_ptr_q);
    end
  endtask

  task automatic test_squash();
    do_reset();
    @(negedge clock);
    set_in(8'hFF);
    tick();
    @(negedge clock);
    set_in(8'b00000001);
    squash = 1'b1;
    tick();
    total++;
    if (cdb_valid !== 3'b000 || fu_stall !== 8'h00) begin
      bad++;
      $display("FAIL squash valid=%b stall=%b exp 0/0", cdb_valid, fu_stall);
    end
    @(negedge clock);
    set_in('0);
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (cdb_valid !== 3'b000) begin
        bad++;
        $display("FAIL squash_after c%0d valid=%b exp 000", c, cdb_valid);
      end
    end
  endtask

  task automatic test_stall_violation();
    int seen = 0;
    do_reset();
    @(negedge clock);
    set_in(8'hFF);
    tick();
    @(negedge clock);
    set_in(8'b00001000);
    val[3] = 32'ha8c1e910;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int l = 0; l < W; l++) begin
        if (cdb_valid[l] && cdb_fu_idx[l] == 3'd3) begin
          seen++;
          total++;
          if (wb_value[l] !== 32'h1000_0003) begin
            bad++;
            $display("FAIL stall_viol_value got=%h exp=10000003", wb_value[l]);
          end
        end
      end
      @(negedge clock);
      set_in('0);
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL stall_viol_count got=%0d exp=1", seen);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [N-1:0] exp_stall;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        mask[i] = ~m_held[i];
        pr[i] = 6'($urandom);
        val[i] = $urandom;
        br[i] = $urandom_range(0, 1) == 1;
      end
      fin = 8'($urandom);
      if ($urandom_range(0, 7) != 0) fin = fin & mask;
      squash = ($urandom_range(0, 15) == 0);
      tick();
      for (int i = 0; i < N; i++) exp_stall[i] = m_held[i];
      total++;
      if (cdb_valid !== e_valid || fu_stall !== exp_stall) begin
        bad++;
        $display("FAIL rand c%0d valid=%b stall=%b exp %b/%b", c, cdb_valid, fu_stall, e_valid, exp_stall);
      end
      for (int l = 0; l < W; l++) begin
        if (e_valid[l]) begin
          total++;
          if (cdb_tag[l] !== e_tag[l] || wb_value[l] !== e_val[l]
              || cdb_take_branch[l] !== e_br[l] || cdb_fu_idx[l] !== 3'(e_idx[l])) begin
            bad++;
            $display("FAIL rand c%0d lane%0d tag=%h val=%h br=%b idx=%0d exp %h/%h/%b/%0d", c, l,
                     cdb_tag[l], wb_value[l], cdb_take_branch[l], cdb_fu_idx[l], e_tag[l], e_val[l], e_br[l], e_idx[l]);
          end
        end
      end
    end
    @(negedge clock);
    set_in('0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_light_load();
    test_overload();
    test_wrap();
    test_squash();
    test_stall_violation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
